// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache on the CPU fetch path.
// Lookups are combinational from PC. A miss stalls the CPU through busywait
// while a two-state FSM refills the indexed 16-byte line from instruction
// memory. miss_count tracks completed refills and saturates at MISS_SAT.
module icache #(
  parameter int unsigned PC_BITS  = 10,
  parameter int unsigned BLOCKS   = 8,
  // Ceiling of the refill counter; the default is the full 16-bit range.
  // A lower ceiling lets a short run reach the saturation point.
  parameter logic [15:0] MISS_SAT = 16'hFFFF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          PC,
  output logic [31:0]          INSTRUCTION,
  output logic                 busywait,
  output logic                 mem_read,
  output logic [PC_BITS-5:0]   mem_address,
  input  logic [127:0]         mem_readdata,
  input  logic                 mem_busywait,
  output logic [15:0]          miss_count
);

  // Address layout: | tag | index | word | byte |, byte offset ignored.
  localparam int unsigned IDX_W = $clog2(BLOCKS);
  localparam int unsigned BLK_W = PC_BITS - 4;
  localparam int unsigned TAG_W = BLK_W - IDX_W;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MEM_READ = 1'b1;

  // Control state (reset)
  logic [0:0]        state_q, state_d;
  logic [BLOCKS-1:0] valid_q, valid_d;
  logic [15:0]       miss_count_q, miss_count_d;

  // Datapath state (not reset)
  logic [BLK_W-1:0]  addr_q, addr_d;
  logic [TAG_W-1:0]  tag_q  [BLOCKS];
  logic [127:0]      data_q [BLOCKS];

  // PC fields
  logic [TAG_W-1:0]  pc_tag;
  logic [IDX_W-1:0]  pc_idx;
  logic [1:0]        pc_word;
  logic              unused_pc;

  // Lookup and refill control
  logic              hit;
  logic              fill_done;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v >= MISS_SAT) ? v : v + 16'd1;
  endfunction

  // Select one 32-bit instruction out of a 128-bit line; word n sits at [32n+31:32n].
  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] w);
    logic [31:0] r;
    case (w)
      2'd0:    r = blk[31:0];
      2'd1:    r = blk[63:32];
      2'd2:    r = blk[95:64];
      default: r = blk[127:96];
    endcase
    return r;
  endfunction

  assign pc_tag  = PC[PC_BITS-1 -: TAG_W];
  assign pc_idx  = PC[4 +: IDX_W];
  assign pc_word = PC[3:2];

  // High address bits and the byte offset never take part in a lookup.
  assign unused_pc = ^{PC[31:PC_BITS], PC[1:0]};

  // The refill targets the address latched at the miss, not the live PC,
  // so a CPU that moves PC during a stall cannot redirect the line write.
  assign fill_idx  = addr_q[IDX_W-1:0];
  assign fill_tag  = addr_q[BLK_W-1 -: TAG_W];
  assign fill_done = (state_q == MEM_READ) && !mem_busywait;

  assign hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  // Next-state logic: a miss in IDLE starts a refill, memory ready ends it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          state_d = MEM_READ;
          addr_d  = PC[PC_BITS-1:4];
        end
      end
      MEM_READ: begin
        if (!mem_busywait) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid bits and refill counter update on the edge that lands the line.
  always_comb begin
    valid_d      = valid_q;
    miss_count_d = miss_count_q;
    if (fill_done) begin
      valid_d[fill_idx] = 1'b1;
      miss_count_d      = sat_inc(miss_count_q);
    end
  end

  // Control registers; reset invalidates every line and abandons a refill.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag/data arrays and the latched block address; a refill cut off by reset is dropped.
  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
    if (fill_done && !RESET) begin
      data_q[fill_idx] <= mem_readdata;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

  // busywait is held low during reset so the CPU can reload its PC.
  assign busywait    = RESET ? 1'b0 : ((state_q == MEM_READ) || !hit);
  assign mem_read    = (state_q == MEM_READ);
  assign mem_address = addr_q;
  assign INSTRUCTION = word_sel(data_q[pc_idx], pc_word);
  assign miss_count  = miss_count_q;

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache on the CPU fetch path. Responds to the CPU's `PC` with the 32-bit `INSTRUCTION` and stalls the CPU via `busywait` on a miss. Refills 16-byte blocks from instruction memory over a block-read handshake. Sits between `cpu` (PC out / INSTRUCTION in) and the instruction memory.

## Interface
Parameters:
- `PC_BITS`, 10: byte-address bits of PC used. Fixed layout is tag = PC[9:7], index = PC[6:4], word offset = PC[3:2]. PC[1:0] and PC[31:10] are ignored.
- `BLOCKS`, 8: number of cache lines, each 128 bits (4 instructions).

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge
- `RESET`  in  1  synchronous, active-high reset
- `PC`  in  32  fetch address from CPU
- `INSTRUCTION`  out  32  instruction word for `PC`; valid when `busywait`=0
- `busywait`  out  1  stall to CPU; CPU must hold `PC` while high
- `mem_read`  out  1  block-read request to instruction memory
- `mem_address`  out  6  block address = {tag, index} = PC[9:4]
- `mem_readdata`  in  128  refill block; word n at bits [32n+31:32n]
- `mem_busywait`  in  1  memory busy; asserted combinationally while `mem_read`=1 until data is valid
- `miss_count`  out  16  saturating count of refills completed since reset

## Operation
- Storage per line: valid bit, 3-bit tag, 128-bit data.
- Hit = valid[index] & (tag[index] == PC[9:7]). Evaluated combinationally from the current `PC` and array contents.
- `INSTRUCTION` = data[index] word PC[3:2]: 00 → [31:0], 01 → [63:32], 10 → [95:64], 11 → [127:96].
- Two-state FSM:
  - `IDLE`: `mem_read`=0. `busywait` = ~hit (combinational). On a miss at the clock edge, go to `MEM_READ` and latch `mem_address` = PC[9:4].
  - `MEM_READ`: `mem_read`=1, `busywait`=1, `mem_address` held.
    - Edge with `mem_busywait`=1: stay.
    - Edge with `mem_busywait`=0: write `mem_readdata` to data[index], set tag[index]=PC[9:7] and valid[index]=1, increment `miss_count` (hold at 16'hFFFF), then go to `IDLE`.
- A refill always overwrites the indexed line. There is no write path and no dirty state.
- Reset, on any edge with `RESET`=1, in any state:
  - FSM goes to `IDLE`, all valid bits clear, `miss_count`=0.
  - `mem_read` is 0 from the next cycle. An in-flight refill is abandoned and its data discarded.
  - Data and tag arrays are not cleared.
- Reset values after the reset edge: `mem_read`=0, `miss_count`=0.
  - `busywait` is 1 in the first cycle with `RESET`=0, since every line is invalid and the lookup misses.
  - `busywait` is forced to 0 while `RESET`=1 so the CPU PC can reset.
  - `INSTRUCTION` is don't-care until the first refill completes.

## Timing
- Hit: zero added latency. `INSTRUCTION` and `busywait`=0 are valid in the same cycle `PC` is stable.
- Miss, with memory holding `mem_busywait` for L cycles after the request:
  - `busywait` is high in the `IDLE` detect cycle plus L+1 `MEM_READ` cycles.
  - The instruction is returned in the next `IDLE` cycle as a hit.
  - Total stall is L+2 cycles.
- `mem_readdata` is sampled only on the `MEM_READ` edge where `mem_busywait`=0.
- `PC` changing while `busywait`=1 is a CPU protocol violation. The fill targets the latched `mem_address`, and the next lookup uses the new `PC`.
- A `miss_count` increment and its saturation take effect at the same edge as the line write.

## Test plan
- Cold miss: reset, then `PC`=0x000 with a memory of L=5 returning 128'h0000000C_00000008_00000004_00000000.
  - Expect `busywait` high for 7 cycles, `mem_read` high for 6 cycles, `mem_address`=0.
  - Then `INSTRUCTION`=0x00000000 and `miss_count`=1.
- Same-block hits: after the cold miss, `PC`=0x004, 0x008, 0x00C.
  - Expect `busywait`=0 each cycle, `INSTRUCTION`=4, 8, C, and no `mem_read`.
- Conflict eviction: `PC`=0x000, then 0x080 (same index 0, tag 1), then 0x000.
  - Expect three refills, `mem_address`=0x00, 0x08, 0x00, and `miss_count`=3.
- Reset mid-refill: assert `RESET` at cycle 3 of `MEM_READ`.
  - Expect `mem_read`=0 on the next cycle, `miss_count`=0, and line 0 invalid.
  - The next `PC`=0x000 fetch misses again.
- Saturation: force 65 537 refills.
  - Expect `miss_count` to stop at 16'hFFFF.
- Word-select sweep: fill index 5 (`PC`=0x050) with distinct words, then fetch 0x050, 0x054, 0x058, 0x05C.
  - Expect words 0 through 3 in order, all hits.
